multi_clkgen: RTL and testbench

Synthesisable multi-channel clock/pulse generator, parametrised in channel count and counter width. Each channel produces a waveform on its own output, all derived from the single system clock. Each waveform has a programmable start phase, high time and low time, counted in system-clock cycles. The block is the bench-and-RTL replacement for behavioural delay-based clock generation. Typical use is deriving skewed or low-rate strobes, for example a 50%-duty divided clock with a 7-cycle offset.

---
 rtl/multi_clkgen.sv | 210 +++++++++++++++++++++
 tb/tb_multi_clkgen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_clkgen.sv
// ---------------------------------------------------------------------------
// multi_clkgen
//   Multi-channel clock/pulse generator. Each channel drives its own output
//   with a programmable start phase, high time and low time, counted in
//   cycles of the single system clock. Channels are fully independent.
//
//   Optional feature macro: MULTI_CLKGEN_SYNC_EN
//     When defined, adds the 'sync' input. A high sync restarts every enabled
//     channel from IDLE, which phase-aligns all channels.
//
// Parameters
//   NCH  number of channels (1..16)
//   CW   width of the phase / ton / toff counters
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sync       in   (MULTI_CLKGEN_SYNC_EN only) restart all enabled channels
//   en         in   [NCH] per-channel run enable (level)
//   cfg_we     in   config write strobe
//   cfg_ch     in   [4] target channel; values >= NCH are ignored
//   cfg_phase  in   [CW] cycles from enable to first high
//   cfg_ton    in   [CW] high time in cycles (0 = constant low)
//   cfg_toff   in   [CW] low time in cycles (0 = constant high)
//   clk_out    out  [NCH] generated waveforms, registered
//   rise       out  [NCH] one-cycle strobe in the first cycle of each high
//   cfg_pend   out  [NCH] config written but not yet applied
// ---------------------------------------------------------------------------
module multi_clkgen #(
    parameter int NCH = 2,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MULTI_CLKGEN_SYNC_EN
    input  logic           sync,
`endif
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_ch,
    input  logic [CW-1:0]  cfg_phase,
    input  logic [CW-1:0]  cfg_ton,
    input  logic [CW-1:0]  cfg_toff,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] cfg_pend
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic sync_s;

`ifdef MULTI_CLKGEN_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam logic [3:0] CH_ID = 4'(g);

        state_t        state_r, state_s, hi_state_s;
        logic [CW-1:0] cnt_r, cnt_s, hi_cnt_s;
        logic [CW-1:0] act_phase_r, act_ton_r, act_toff_r;
        logic [CW-1:0] pnd_phase_r, pnd_ton_r, pnd_toff_r;
        logic [CW-1:0] eff_phase_s, eff_ton_s, eff_toff_s;
        logic          wr_s, apply_s;
        logic          clk_r, rise_r, pend_r;

        // Channel next-state: config selection, apply points and FSM stepping
        always_comb begin
            wr_s = cfg_we & (cfg_ch == CH_ID);

            // Apply points: leaving/entering IDLE, a restart, the LOW->HIGH
            // boundary (also every cycle while parked low), and every cycle
            // while parked high.
            apply_s = ~en[g]
                    | (state_r == ST_IDLE)
                    | sync_s
                    | ((state_r == ST_LOW)  && (cnt_r == ZERO))
                    | ((state_r == ST_HIGH) && (cnt_r == ZERO) && (act_toff_r == ZERO));

            // A write landing on an apply point goes straight through.
            if (apply_s && wr_s) begin
                eff_phase_s = cfg_phase;
                eff_ton_s   = cfg_ton;
                eff_toff_s  = cfg_toff;
            end else if (apply_s) begin
                eff_phase_s = pnd_phase_r;
                eff_ton_s   = pnd_ton_r;
                eff_toff_s  = pnd_toff_r;
            end else begin
                eff_phase_s = act_phase_r;
                eff_ton_s   = act_ton_r;
                eff_toff_s  = act_toff_r;
            end

            // Entering a high phase with ton=0 parks the channel in LOW.
            if (eff_ton_s == ZERO) begin
                hi_state_s = ST_LOW;
                hi_cnt_s   = ZERO;
            end else begin
                hi_state_s = ST_HIGH;
                hi_cnt_s   = eff_ton_s - ONE;
            end

            state_s = state_r;
            cnt_s   = cnt_r;

            if (!en[g]) begin
                state_s = ST_IDLE;
                cnt_s   = ZERO;
            end else if ((state_r == ST_IDLE) || sync_s) begin
                if (eff_phase_s == ZERO) begin
                    state_s = hi_state_s;
                    cnt_s   = hi_cnt_s;
                end else begin
                    state_s = ST_PHASE;
                    cnt_s   = eff_phase_s - ONE;
                end
            end else begin
                case (state_r)
                    ST_PHASE: begin
                        if (cnt_r == ZERO) begin
                            state_s = hi_state_s;
                            cnt_s   = hi_cnt_s;
                        end else begin
                            cnt_s = cnt_r - ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_r != ZERO) begin
                            cnt_s = cnt_r - ONE;
                        end else if (eff_toff_s == ZERO) begin
                            // toff=0: park high
                            state_s = ST_HIGH;
                            cnt_s   = ZERO;
                        end else begin
                            state_s = ST_LOW;
                            cnt_s   = eff_toff_s - ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_r == ZERO) begin
                            state_s = hi_state_s;
                            cnt_s   = hi_cnt_s;
                        end else begin
                            cnt_s = cnt_r - ONE;
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                        cnt_s   = ZERO;
                    end
                endcase
            end
        end

        // Channel state, config sets and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r     <= ST_IDLE;
                cnt_r       <= ZERO;
                act_phase_r <= ZERO;
                act_ton_r   <= ONE;
                act_toff_r  <= ONE;
                pnd_phase_r <= ZERO;
                pnd_ton_r   <= ONE;
                pnd_toff_r  <= ONE;
                pend_r      <= 1'b0;
                clk_r       <= 1'b0;
                rise_r      <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                if (apply_s) begin
                    act_phase_r <= eff_phase_s;
                    act_ton_r   <= eff_ton_s;
                    act_toff_r  <= eff_toff_s;
                end
                if (wr_s) begin
                    pnd_phase_r <= cfg_phase;
                    pnd_ton_r   <= cfg_ton;
                    pnd_toff_r  <= cfg_toff;
                end
                if (apply_s) begin
                    pend_r <= 1'b0;
                end else if (wr_s) begin
                    pend_r <= 1'b1;
                end
                // Gating with en makes a disable visible on the very next cycle.
                clk_r  <= (state_r == ST_HIGH) & en[g];
                rise_r <= (state_r == ST_HIGH) & en[g] & ~clk_r;
            end
        end

        assign clk_out[g]  = clk_r;
        assign rise[g]     = rise_r;
        assign cfg_pend[g] = pend_r;
    end

endmodule

// File: tb/tb_multi_clkgen.sv
// ---------------------------------------------------------------------------
// tb_multi_clkgen
//   Directed bench for multi_clkgen (NCH=2, CW=8). A table of per-cycle
//   vectors covers reset, divide-by-2, degenerate settings, invalid channel,
//   disable and reset-with-write; hand sequences cover the skewed clock with
//   mid-period reconfiguration and, with MULTI_CLKGEN_SYNC_EN, sync alignment.
// ---------------------------------------------------------------------------
module tb_multi_clkgen;

    logic       clk = 1'b0;
    logic       rst;
`ifdef MULTI_CLKGEN_SYNC_EN
    logic       sync;
`endif
    logic [1:0] en;
    logic       cfg_we;
    logic [3:0] cfg_ch;
    logic [7:0] cfg_phase, cfg_ton, cfg_toff;
    logic [1:0] clk_out, rise, cfg_pend;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_clkgen #(.NCH(2), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MULTI_CLKGEN_SYNC_EN
        .sync      (sync),
`endif
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_phase (cfg_phase),
        .cfg_ton   (cfg_ton),
        .cfg_toff  (cfg_toff),
        .clk_out   (clk_out),
        .rise      (rise),
        .cfg_pend  (cfg_pend)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] en;
        logic       we;
        logic [3:0] ch;
        logic [7:0] ph, ton, toff;
        logic [1:0] eclk, erise, epend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic [1:0] e,
                       input logic w, input logic [3:0] c,
                       input logic [7:0] p, input logic [7:0] t, input logic [7:0] f,
                       input logic [1:0] ec, input logic [1:0] er, input logic [1:0] ep);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.we = w; v.ch = c;
        v.ph = p; v.ton = t; v.toff = f;
        v.eclk = ec; v.erise = er; v.epend = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] e, input logic w,
                         input logic [3:0] c, input logic [7:0] p,
                         input logic [7:0] t, input logic [7:0] f);
        rst = r; en = e; cfg_we = w; cfg_ch = c;
        cfg_phase = p; cfg_ton = t; cfg_toff = f;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] ec,
                         input logic [1:0] er, input logic [1:0] ep);
        n_total++;
        if ({clk_out, rise, cfg_pend} === {ec, er, ep}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got clk_out=%b rise=%b cfg_pend=%b, expected clk_out=%b rise=%b cfg_pend=%b",
                     nm, clk_out, rise, cfg_pend, ec, er, ep);
        end
    endtask

    task automatic check_clk(input string nm, input logic [1:0] ec);
        n_total++;
        if (clk_out === ec) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got clk_out=%b, expected clk_out=%b", nm, clk_out, ec);
        end
    endtask

    initial begin
        logic ec, er, ep, prev;

        drive(1'b1, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
`ifdef MULTI_CLKGEN_SYNC_EN
        sync = 1'b0;
`endif

        //  name          rst  en     we    ch    ph    ton   toff  clk    rise   pend
        add("reset0",     1'b1, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("reset1",     1'b1, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        // divide-by-2 from reset config
        add("div2_e0",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("div2_e1",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00);
        add("div2_e2",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("div2_e3",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00);
        add("div2_e4",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("div2_off",   1'b0, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        // ton=0: constant low
        add("ton0_cfg",   1'b0, 2'b00, 1'b1, 4'd0, 8'd0, 8'd0, 8'd3, 2'b00, 2'b00, 2'b00);
        add("ton0_a",     1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("ton0_b",     1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("ton0_c",     1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        // ton=4, toff=0 written while parked low: write-through, constant high
        add("toff0_wr",   1'b0, 2'b01, 1'b1, 4'd0, 8'd0, 8'd4, 8'd0, 2'b00, 2'b00, 2'b00);
        add("toff0_a",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00);
        add("toff0_b",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("toff0_c",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("toff0_d",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("toff0_e",    1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        // write to channel NCH must not touch any channel
        add("badch_wr",   1'b0, 2'b01, 1'b1, 4'd2, 8'd0, 8'd0, 8'd5, 2'b01, 2'b00, 2'b00);
        add("badch_a",    1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("badch_b",    1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b10, 2'b00);
        add("badch_c",    1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("badch_d",    1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b10, 2'b00);
        // ch1 at 3/3, then drop en[1] during its high phase
        add("dis_cfg",    1'b0, 2'b01, 1'b1, 4'd1, 8'd0, 8'd3, 8'd3, 2'b01, 2'b00, 2'b00);
        add("dis_a",      1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("dis_b",      1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b10, 2'b00);
        add("dis_drop",   1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        add("dis_after",  1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
        // reset with a same-cycle write: config returns to 0/1/1
        add("rstwr",      1'b1, 2'b11, 1'b1, 4'd0, 8'd0, 8'd9, 8'd9, 2'b00, 2'b00, 2'b00);
        add("rstwr_e0",   1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("rstwr_e1",   1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00);
        add("rstwr_e2",   1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        add("rstwr_e3",   1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00);
        add("rstwr_off",  1'b0, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].ch,
                  vecs[i].ph, vecs[i].ton, vecs[i].toff);
            step;
            check(vecs[i].name, vecs[i].eclk, vecs[i].erise, vecs[i].epend);
        end

        // Skewed clock 7/5/5, then ton=2/toff=3 written during a high phase.
        drive(1'b0, 2'b00, 1'b1, 4'd0, 8'd7, 8'd5, 8'd5);
        step;
        check("skew_cfg", 2'b00, 2'b00, 2'b00);
        prev = 1'b0;
        for (int k = 0; k < 48; k++) begin
            drive(1'b0, 2'b01, (k == 29), 4'd0, 8'd7, 8'd2, 8'd3);
            step;
            if (k < 38) ec = (k >= 8) && (((k - 8) % 10) < 5);
            else        ec = (((k - 38) % 5) < 2);
            er   = ec && !prev;
            ep   = (k >= 29) && (k < 37);
            prev = ec;
            check($sformatf("skew_k%0d", k), {1'b0, ec}, {1'b0, er}, {1'b0, ep});
        end
        drive(1'b0, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
        step;
        check("skew_off", 2'b00, 2'b00, 2'b00);

`ifdef MULTI_CLKGEN_SYNC_EN
        // ch0 0/2/2, ch1 3/2/2 started one cycle apart, then aligned by sync.
        drive(1'b0, 2'b00, 1'b1, 4'd0, 8'd0, 8'd2, 8'd2);
        step;
        drive(1'b0, 2'b00, 1'b1, 4'd1, 8'd3, 8'd2, 8'd2);
        step;
        drive(1'b0, 2'b01, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
        step;
        drive(1'b0, 2'b11, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
        for (int k = 1; k < 8; k++) step;
        sync = 1'b1;
        step;
        sync = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step;
            check_clk($sformatf("sync_j%0d", j),
                      {(j >= 4) && (((j - 4) % 4) < 2), ((j - 1) % 4) < 2});
        end
        drive(1'b0, 2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
        step;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
